// File: rtl/conv_pe_seq_if.sv
// Bus between the operand/result memory and the convolution PE:
// launch strobe, 4x4 input tile, 3x3 filter, 2x2 results and status.
interface conv_pe_seq_if #(
    parameter int DW = 8
);
    logic          start;
    logic [DW-1:0] a11, a12, a13, a14;
    logic [DW-1:0] a21, a22, a23, a24;
    logic [DW-1:0] a31, a32, a33, a34;
    logic [DW-1:0] a41, a42, a43, a44;
    logic [DW-1:0] b11, b12, b13;
    logic [DW-1:0] b21, b22, b23;
    logic [DW-1:0] b31, b32, b33;
    logic [DW-1:0] c11, c12, c21, c22;
    logic          done;
    logic          busy;

    // Memory side: supplies operands and the launch pulse, collects results.
    modport master (
        output start,
        output a11, a12, a13, a14, a21, a22, a23, a24,
        output a31, a32, a33, a34, a41, a42, a43, a44,
        output b11, b12, b13, b21, b22, b23, b31, b32, b33,
        input  c11, c12, c21, c22, done, busy
    );

    // PE side.
    modport slave (
        input  start,
        input  a11, a12, a13, a14, a21, a22, a23, a24,
        input  a31, a32, a33, a34, a41, a42, a43, a44,
        input  b11, b12, b13, b21, b22, b23, b31, b32, b33,
        output c11, c12, c21, c22, done, busy
    );
endinterface

// File: rtl/conv_pe_seq.sv
// Sequential 3x3 valid convolution over a 4x4 tile: one MAC per cycle,
// 36 MACs per run, saturating 2x2 result registers, one-cycle done pulse.
module conv_pe_seq #(
    parameter int DW = 8,
    parameter int AW = 20
) (
    input  logic          clk,
    input  logic          reset,
    conv_pe_seq_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [DW-1:0] SAT = {DW{1'b1}};

    state_t          state, state_nx;
    logic [1:0]      o;                  // output index: c11, c12, c21, c22
    logic [3:0]      t;                  // filter tap index 0..8
    logic [AW-1:0]   acc;
    logic [DW-1:0]   snap_a [16];
    logic [DW-1:0]   snap_b [9];
    logic [DW-1:0]   res    [4];
    logic [DW-1:0]   in_a   [16];
    logic [DW-1:0]   in_b   [9];

    logic [1:0]      tap_i, tap_j, row, col;
    logic [3:0]      a_idx;
    logic [2*DW-1:0] prod;
    logic [AW-1:0]   sum;
    logic [DW-1:0]   res_sat;
    logic            last_tap, last_out;

    // Flatten the operand bus row-major so the snapshot can be loaded in a loop.
    assign in_a[0]  = bus.a11;  assign in_a[1]  = bus.a12;
    assign in_a[2]  = bus.a13;  assign in_a[3]  = bus.a14;
    assign in_a[4]  = bus.a21;  assign in_a[5]  = bus.a22;
    assign in_a[6]  = bus.a23;  assign in_a[7]  = bus.a24;
    assign in_a[8]  = bus.a31;  assign in_a[9]  = bus.a32;
    assign in_a[10] = bus.a33;  assign in_a[11] = bus.a34;
    assign in_a[12] = bus.a41;  assign in_a[13] = bus.a42;
    assign in_a[14] = bus.a43;  assign in_a[15] = bus.a44;
    assign in_b[0]  = bus.b11;  assign in_b[1]  = bus.b12;
    assign in_b[2]  = bus.b13;  assign in_b[3]  = bus.b21;
    assign in_b[4]  = bus.b22;  assign in_b[5]  = bus.b23;
    assign in_b[6]  = bus.b31;  assign in_b[7]  = bus.b32;
    assign in_b[8]  = bus.b33;

    // Tap decode: window origin (r,c) = (o[1],o[0]), offset (i,j) = (t/3, t%3).
    always_comb begin
        tap_i    = 2'(t / 4'd3);
        tap_j    = 2'(t % 4'd3);
        row      = {1'b0, o[1]} + tap_i;
        col      = {1'b0, o[0]} + tap_j;
        a_idx    = {row, col};
        prod     = (2*DW)'(snap_a[a_idx]) * (2*DW)'(snap_b[t]);
        sum      = acc + AW'(prod);
        res_sat  = (sum > AW'(SAT)) ? SAT : sum[DW-1:0];
        last_tap = (t == 4'd8);
        last_out = (o == 2'd3);
    end

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state logic; start outside IDLE is simply not looked at.
    // NOTE: the default assignment first means no path leaves state_nx unassigned, so no latch.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = RUN;
            RUN:     if (last_tap && last_out) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign bus.done = (state == DONE);
    assign bus.busy = (state != IDLE);

    // Snapshot on launch, then one MAC per RUN cycle with a saturating write on tap 8.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o   <= '0;
            t   <= '0;
            acc <= '0;
            // NOTE: these small register arrays are reset on purpose: an aborted run must leave zeros visible.
            for (int k = 0; k < 16; k++) snap_a[k] <= '0;
            for (int k = 0; k < 9; k++)  snap_b[k] <= '0;
            for (int k = 0; k < 4; k++)  res[k]    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        for (int k = 0; k < 16; k++) snap_a[k] <= in_a[k];
                        for (int k = 0; k < 9; k++)  snap_b[k] <= in_b[k];
                        o   <= '0;
                        t   <= '0;
                        acc <= '0;
                    end
                end
                RUN: begin
                    if (last_tap) begin
                        res[o] <= res_sat;
                        acc    <= '0;
                        t      <= '0;
                        o      <= o + 2'd1;
                    end else begin
                        acc <= sum;
                        t   <= t + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.c11 = res[0];
    assign bus.c12 = res[1];
    assign bus.c21 = res[2];
    assign bus.c22 = res[3];
endmodule
